// File: rtl/frame_parser_pkg.sv
// rtl/frame_parser_pkg.sv - frame parser state encoding and default parameters (FRAME_PARSER_CHK_EN adds CHK)
package frame_parser_pkg;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam int         DEF_MAX_LEN   = 16;
  localparam int         DEF_TIMEOUT   = 64;

`ifdef FRAME_PARSER_CHK_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHK     = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;
`endif

  function automatic logic len_legal(input logic [7:0] len, input logic [7:0] max_len);
    return (len != 8'd0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - in-frame idle counter; expired pulses on the TIMEOUT-th consecutive enabled cycle
module frame_timer
  import frame_parser_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk_100M,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [9:0] LAST = 10'(TIMEOUT - 1);

  logic [9:0] cnt;

  assign expired = enable && !clear && (cnt == LAST);

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      cnt <= 10'd0;
    end else if (clear || expired) begin
      cnt <= 10'd0;
    end else if (enable) begin
      cnt <= cnt + 10'd1;
    end
  end

endmodule

// File: rtl/frame_parser.sv
// rtl/frame_parser.sv - SYNC/LEN/payload[/checksum] frame parser; checksum stage built only with FRAME_PARSER_CHK_EN
module frame_parser
  import frame_parser_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter int         MAX_LEN   = DEF_MAX_LEN,
  parameter int         TIMEOUT   = DEF_TIMEOUT
) (
  input  logic       clk_100M,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic [7:0] payload_out,
  output logic       payload_valid,
  output logic       frame_done,
  output logic       chk_err,
  output logic       len_err,
  output logic       timeout,
  output logic       busy
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] payload_d;
  logic       payload_valid_d, frame_done_d, len_err_d, timeout_d;
  logic       expired;

`ifdef FRAME_PARSER_CHK_EN
  logic [7:0] sum_q, sum_d;
  logic       chk_err_d;
`endif

  assign busy = (state_q != ST_IDLE);

  // Any accepted byte restarts the idle count, so a byte arriving on the expiry cycle wins.
  frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_100M (clk_100M),
    .rst      (rst),
    .clear    (data_valid || (state_q == ST_IDLE)),
    .enable   ((state_q != ST_IDLE) && !data_valid),
    .expired  (expired)
  );

  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    cnt_d           = cnt_q;
    payload_d       = payload_out;
    payload_valid_d = 1'b0;
    frame_done_d    = 1'b0;
    len_err_d       = 1'b0;
    timeout_d       = 1'b0;
`ifdef FRAME_PARSER_CHK_EN
    sum_d           = sum_q;
    chk_err_d       = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (data_valid && (data_in == SYNC_BYTE)) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (data_valid) begin
          if (len_legal(data_in, MAX_LEN_B)) begin
            len_d   = data_in;
            cnt_d   = 8'd0;
`ifdef FRAME_PARSER_CHK_EN
            sum_d   = 8'd0;
`endif
            state_d = ST_PAYLOAD;
          end else begin
            len_err_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (data_valid) begin
          payload_d       = data_in;
          payload_valid_d = 1'b1;
          cnt_d           = cnt_q + 8'd1;
`ifdef FRAME_PARSER_CHK_EN
          sum_d           = sum_q + data_in;
          if (cnt_q == len_q - 8'd1) state_d = ST_CHK;
`else
          if (cnt_q == len_q - 8'd1) begin
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end
`endif
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
`ifdef FRAME_PARSER_CHK_EN
      ST_CHK: begin
        if (data_valid) begin
          frame_done_d = 1'b1;
          chk_err_d    = (data_in != sum_q);
          state_d      = ST_IDLE;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      len_q         <= 8'd0;
      cnt_q         <= 8'd0;
      payload_out   <= 8'h00;
      payload_valid <= 1'b0;
      frame_done    <= 1'b0;
      len_err       <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      payload_out   <= payload_d;
      payload_valid <= payload_valid_d;
      frame_done    <= frame_done_d;
      len_err       <= len_err_d;
      timeout       <= timeout_d;
    end
  end

`ifdef FRAME_PARSER_CHK_EN
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      sum_q   <= 8'd0;
      chk_err <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      chk_err <= chk_err_d;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_parser.sv
// tb/tb_frame_parser.sv - scoreboard bench for frame_parser (checksum frames when FRAME_PARSER_CHK_EN is defined)
module tb_frame_parser;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TMO  = 64;

  logic       clk_100M = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic [7:0] payload_out;
  logic       payload_valid, frame_done, chk_err, len_err, timeout, busy;

  typedef struct {
    int         kind;
    logic [7:0] data;
    bit         done;
    bit         cerr;
    int         when;
  } ev_t;

  ev_t sbq[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;

  frame_parser #(.SYNC_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT(64)) dut (
    .clk_100M      (clk_100M),
    .rst           (rst),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .payload_out   (payload_out),
    .payload_valid (payload_valid),
    .frame_done    (frame_done),
    .chk_err       (chk_err),
    .len_err       (len_err),
    .timeout       (timeout),
    .busy          (busy)
  );

  always #5 clk_100M = ~clk_100M;
  always @(posedge clk_100M) cyc <= cyc + 1;

  // kind: 0 payload byte, 1 checksum frame_done, 2 len_err, 3 timeout
  always @(negedge clk_100M) begin : monitor
    ev_t        e;
    logic [4:0] got, want;
    if (!rst && (payload_valid || frame_done || chk_err || len_err || timeout)) begin
      got = {payload_valid, frame_done, chk_err, len_err, timeout};
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_strobe got pv,fd,ce,le,to=%b at cyc %0d", got, cyc);
      end else begin
        e = sbq.pop_front();
        want = {e.kind == 0, (e.kind == 1) || (e.kind == 0 && e.done), e.cerr, e.kind == 2, e.kind == 3};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL strobes got pv,fd,ce,le,to=%b expected %b at cyc %0d", got, want, cyc);
        end
        if (e.kind == 0) begin
          total++;
          if (payload_out !== e.data) begin
            bad++;
            $display("FAIL payload_out got %h expected %h", payload_out, e.data);
          end
        end
        total++;
        if (cyc !== e.when) begin
          bad++;
          $display("FAIL event_timing kind %0d got cyc %0d expected cyc %0d", e.kind, cyc, e.when);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    data_in = b;
    data_valid = 1'b1;
    @(posedge clk_100M); #1;
    data_valid = 1'b0;
    data_in = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_100M); #1;
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] d, input bit done, input bit cerr, input int lat);
    ev_t e;
    e.kind = kind; e.data = d; e.done = done; e.cerr = cerr; e.when = cyc + lat;
    sbq.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] pl [16], input logic [7:0] n);
    send_byte(SYNC);
    send_byte(n);
    for (int i = 0; i < int'(n); i++) begin
`ifdef FRAME_PARSER_CHK_EN
      expect_ev(0, pl[i], 1'b0, 1'b0, 1);
`else
      expect_ev(0, pl[i], i == int'(n) - 1, 1'b0, 1);
`endif
      send_byte(pl[i]);
    end
  endtask

`ifdef FRAME_PARSER_CHK_EN
  task automatic send_chk(input logic [7:0] c, input bit err);
    expect_ev(1, 8'h00, 1'b1, err, 1);
    send_byte(c);
  endtask
`endif

  task automatic drain(input string name);
    for (int i = 0; i < 30 && sbq.size() != 0; i++) idle(1);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL %s_drain got %0d pending events expected 0", name, sbq.size());
      sbq.delete();
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle busy got %b expected 0", name, busy);
    end
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    idle(2);
    total++;
    if ({payload_out, payload_valid, frame_done, chk_err, len_err, timeout, busy} !== 14'd0) begin
      bad++;
      $display("FAIL reset_outputs got %h expected 0",
               {payload_out, payload_valid, frame_done, chk_err, len_err, timeout, busy});
    end
    rst = 1'b0;
    idle(2);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got %b expected 0", busy);
    end
  endtask

  task automatic test_basic;
    logic [7:0] pl [16];
    pl = '{default: 8'h00};
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
    send_byte(8'h3C);
    send_frame(pl, 8'd3);
`ifdef FRAME_PARSER_CHK_EN
    send_chk(8'h06, 1'b0);
`endif
    drain("basic");
`ifndef FRAME_PARSER_CHK_EN
    pl[0] = 8'h10; pl[1] = 8'h20;
    send_frame(pl, 8'd2);
    drain("no_chk");
`endif
  endtask

`ifdef FRAME_PARSER_CHK_EN
  task automatic test_chk_err;
    logic [7:0] pl [16];
    pl = '{default: 8'h00};
    pl[0] = 8'hFF; pl[1] = 8'h02;
    send_frame(pl, 8'd2);
    send_chk(8'h00, 1'b1);
    drain("chk_err");
  endtask
`endif

  task automatic test_len_err;
    send_byte(SYNC);
    expect_ev(2, 8'h00, 1'b0, 1'b0, 1);
    send_byte(8'h00);
    send_byte(SYNC);
    expect_ev(2, 8'h00, 1'b0, 1'b0, 1);
    send_byte(8'h11);
    drain("len_err");
  endtask

  task automatic test_timeout;
    logic [7:0] pl [16];
    send_byte(SYNC);
    send_byte(8'h02);
    expect_ev(0, 8'hAA, 1'b0, 1'b0, 1);
    send_byte(8'hAA);
    expect_ev(3, 8'h00, 1'b0, 1'b0, TMO);
    idle(TMO - 1);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early busy got %b expected 1", busy);
    end
    idle(1);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_abort busy got %b expected 0", busy);
    end
    pl = '{default: 8'h00};
    pl[0] = SYNC;
    send_frame(pl, 8'd1);
`ifdef FRAME_PARSER_CHK_EN
    send_chk(SYNC, 1'b0);
`endif
    drain("timeout");
  endtask

  task automatic test_timeout_race;
    send_byte(SYNC);
    send_byte(8'h02);
    expect_ev(0, 8'h11, 1'b0, 1'b0, 1);
    send_byte(8'h11);
    idle(TMO - 1);
`ifdef FRAME_PARSER_CHK_EN
    expect_ev(0, 8'h22, 1'b0, 1'b0, 1);
    send_byte(8'h22);
    send_chk(8'h33, 1'b0);
`else
    expect_ev(0, 8'h22, 1'b1, 1'b0, 1);
    send_byte(8'h22);
`endif
    drain("timeout_race");
  endtask

  task automatic test_back_to_back;
    logic [7:0] pl [16];
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < 16; i++) begin
      pl[i] = (i == 5) ? SYNC : 8'(i * 37 + 9);
      sum = sum + pl[i];
    end
    send_frame(pl, 8'd16);
`ifdef FRAME_PARSER_CHK_EN
    send_chk(sum, 1'b0);
`endif
    pl[0] = 8'h7E;
    send_frame(pl, 8'd1);
`ifdef FRAME_PARSER_CHK_EN
    send_chk(8'h00, 1'b1);
`endif
    drain("back_to_back");
  endtask

  task automatic test_reset_mid;
    logic [7:0] pl [16];
    send_byte(SYNC);
    send_byte(8'h04);
    expect_ev(0, 8'h11, 1'b0, 1'b0, 1);
    send_byte(8'h11);
    data_in = 8'h22;
    data_valid = 1'b1;
    @(negedge clk_100M);
    #1 rst = 1'b1;
    #1;
    total++;
    if ({payload_out, payload_valid, frame_done, chk_err, len_err, timeout, busy} !== 14'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs got %h expected 0",
               {payload_out, payload_valid, frame_done, chk_err, len_err, timeout, busy});
    end
    data_valid = 1'b0;
    data_in = 8'h00;
    @(posedge clk_100M); #1;
    rst = 1'b0;
    idle(3);
    pl = '{default: 8'h00};
    pl[0] = 8'h5A; pl[1] = 8'hC3;
    send_frame(pl, 8'd2);
`ifdef FRAME_PARSER_CHK_EN
    send_chk(8'h1D, 1'b0);
`endif
    drain("reset_mid");
  endtask

  initial begin
    test_reset;
    test_basic;
`ifdef FRAME_PARSER_CHK_EN
    test_chk_err;
`endif
    test_len_err;
    test_timeout;
    test_timeout_race;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
